// File: rtl/fft_in_buf32.sv
// fft_in_buf32: serial-to-parallel frame buffer ahead of the 32-point radix-2
// DIF first stage. Collects 32 signed samples in natural order and presents
// them as one flat bus (sample k at [k*IN_W +: IN_W]).
// Build option: define FFT_IN_BUF_DBL_EN for two ping-pong banks, which
// sustains one sample per clock; otherwise a single bank is used.
module fft_in_buf32 #(
  parameter int IN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_sof,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [32*IN_W-1:0]     out_data,
  output logic                   sof_err
);

`ifdef FFT_IN_BUF_DBL_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_st_e;

  bank_st_e               state_q [NB];
  bank_st_e               state_d [NB];
  logic                   fill_ptr_q, fill_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [4:0]             wr_idx_q, wr_idx_d;
  logic                   sof_err_q, sof_err_d;
  logic signed [IN_W-1:0] mem_q [NB][32];

  logic                   accept;
  logic                   xfer;
  logic                   restart;
  logic [4:0]             wr_addr;

  // Handshake flags derive only from bank state, never from in_valid/out_ready
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (b == int'(fill_ptr_q)) in_ready  = (state_q[b] != FULL);
      if (b == int'(rd_ptr_q))   out_valid = (state_q[b] == FULL);
    end
  end

  assign accept  = in_valid && in_ready;
  assign xfer    = out_valid && out_ready;
  // An early start-of-frame throws away the partial frame and restarts at slot 0
  assign restart = in_sof && (wr_idx_q != 5'd0);
  assign wr_addr = in_sof ? 5'd0 : wr_idx_q;

  // Next-state: bank lifecycle, pointer toggles, write index and error pulse
  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_idx_d   = wr_idx_q;
    sof_err_d  = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (xfer && (b == int'(rd_ptr_q))) state_d[b] = EMPTY;
      if (accept && !restart && (b == int'(fill_ptr_q)))
        state_d[b] = (wr_idx_q == 5'd31) ? FULL : FILLING;
    end
    if (accept) begin
      if (restart) begin
        wr_idx_d  = 5'd1;
        sof_err_d = 1'b1;
      end else begin
        wr_idx_d  = wr_idx_q + 5'd1;
      end
    end
`ifdef FFT_IN_BUF_DBL_EN
    if (xfer) rd_ptr_d = ~rd_ptr_q;
    if (accept && !restart && (wr_idx_q == 5'd31)) fill_ptr_d = ~fill_ptr_q;
`endif
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) state_q[b] <= EMPTY;
      fill_ptr_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_idx_q   <= 5'd0;
      sof_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_idx_q   <= wr_idx_d;
      sof_err_q  <= sof_err_d;
    end
  end

  // Sample storage; a FULL bank never sees in_ready, so it is never overwritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++)
        for (int k = 0; k < 32; k++)
          mem_q[b][k] <= '0;
    end else if (accept) begin
      for (int b = 0; b < NB; b++)
        if (b == int'(fill_ptr_q)) mem_q[b][wr_addr] <= in_data;
    end
  end

  // Parallel frame straight from the read bank's registers
  always_comb begin
    out_data = '0;
    for (int b = 0; b < NB; b++)
      if (b == int'(rd_ptr_q))
        for (int k = 0; k < 32; k++)
          out_data[k*IN_W +: IN_W] = mem_q[b][k];
  end

  assign sof_err = sof_err_q;

endmodule
